// File: rtl/vga_pixel_stream.sv
// rtl/vga_pixel_stream.sv - word FIFO, 2-bit pixel shifter and RGB222 palette output stage for a VGA pipeline
module vga_pixel_stream #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic [9:0]  x_pos,
    input  logic        vsync_pulse,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        pal_wr,
    input  logic [1:0]  pal_idx,
    input  logic [5:0]  pal_data,
    output logic [5:0]  rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        underflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   shift_q, shift_d;
    logic [5:0]    pal_q [4];
    logic [5:0]    rgb_q;
    logic          hsync_q, vsync_q;
    logic          underflow_q, underflow_d;

    logic          push, pop, pop_cycle, fifo_empty;
    logic [15:0]   head;
    logic [1:0]    pix_idx;

    // Ready looks only at registered occupancy so a same-cycle pop never frees a slot early.
    assign data_ready = (count_q < DEPTH_C) && !vsync_pulse;

    always_comb begin
        push       = data_valid && data_ready;
        pop_cycle  = !blank_in && (x_pos[2:0] == 3'd0);
        fifo_empty = (count_q == '0);
        pop        = pop_cycle && !fifo_empty;
        head       = mem_q[rd_ptr_q];
        shift_d    = shift_q;
        pix_idx    = 2'b00;
        if (!blank_in) begin
            if (pop_cycle) begin
                if (pop) begin
                    pix_idx = head[15:14];
                    shift_d = {head[13:0], 2'b00};
                end else begin
                    shift_d = 16'h0000;
                end
            end else begin
                pix_idx = shift_q[15:14];
                shift_d = {shift_q[13:0], 2'b00};
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        underflow_d = vsync_pulse ? 1'b0 : (underflow_q || (pop_cycle && fifo_empty));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shift_q     <= 16'h0000;
            underflow_q <= 1'b0;
            rgb_q       <= 6'h00;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            pal_q[0]    <= 6'h00;
            pal_q[1]    <= 6'h15;
            pal_q[2]    <= 6'h2A;
            pal_q[3]    <= 6'h3F;
        end else begin
            if (vsync_pulse) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                count_q <= count_d;
            end
            shift_q     <= shift_d;
            underflow_q <= underflow_d;
            rgb_q       <= blank_in ? 6'h00 : pal_q[pix_idx];
            hsync_q     <= hsync_in;
            vsync_q     <= vsync_in;
            if (pal_wr) begin
                pal_q[pal_idx] <= pal_data;
            end
        end
    end

    assign rgb       = rgb_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_pixel_stream.sv
// tb/tb_vga_pixel_stream.sv - randomized and directed bench for vga_pixel_stream against a queue-based pixel model
module tb_vga_pixel_stream;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, blank_in = 1'b1;
    logic [9:0]  x_pos = '0;
    logic        vsync_pulse = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        pal_wr = 1'b0;
    logic [1:0]  pal_idx = '0;
    logic [5:0]  pal_data = '0;
    logic [5:0]  rgb;
    logic        hsync_out, vsync_out, underflow;

    vga_pixel_stream #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .blank_in(blank_in), .x_pos(x_pos), .vsync_pulse(vsync_pulse),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .pal_wr(pal_wr), .pal_idx(pal_idx), .pal_data(pal_data),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: queued words, current word and how many of its 8 pixels were shown.
    logic [15:0] q_m [$];
    logic [15:0] word_m;
    int          k_m;
    logic [5:0]  pal_m [4];
    logic        und_m;
    logic [5:0]  exp_rgb;
    logic        exp_hs, exp_vs, exp_ready, obs_ready;

    task automatic model_reset();
        q_m.delete();
        word_m = 16'h0;
        k_m = 8;
        pal_m[0] = 6'h00; pal_m[1] = 6'h15; pal_m[2] = 6'h2A; pal_m[3] = 6'h3F;
        und_m = 1'b0;
    endtask

    task automatic step(input logic h, input logic v, input logic b, input logic [9:0] x,
                        input logic vp, input logic [15:0] d, input logic dv,
                        input logic pw, input logic [1:0] pi, input logic [5:0] pd);
        logic       pop_c, empty;
        logic [1:0] idx;
        hsync_in = h; vsync_in = v; blank_in = b; x_pos = x; vsync_pulse = vp;
        data_in = d; data_valid = dv; pal_wr = pw; pal_idx = pi; pal_data = pd;
        #2;
        obs_ready = data_ready;
        exp_ready = (q_m.size() < DEPTH) && !vp;
        pop_c = !b && (x[2:0] == 3'd0);
        empty = (q_m.size() == 0);
        idx = 2'b00;
        if (!b) begin
            if (pop_c) begin
                word_m = empty ? 16'h0 : q_m.pop_front();
                k_m = 0;
            end
            if (k_m < 8) begin
                idx = word_m[15 - 2*k_m -: 2];
                k_m++;
            end
        end
        exp_rgb = b ? 6'h00 : pal_m[idx];
        exp_hs = h;
        exp_vs = v;
        if (vp) und_m = 1'b0;
        else if (pop_c && empty) und_m = 1'b1;
        if (dv && exp_ready) q_m.push_back(d);
        if (vp) q_m.delete();
        if (pw) pal_m[pi] = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        blank_in = 1'b1; x_pos = '0; data_valid = 1'b0; vsync_pulse = 1'b0; pal_wr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_vec++; if (rgb !== 6'h00) begin n_bad++; $display("FAIL reset_rgb got %h want 00", rgb); end
        n_vec++; if (hsync_out !== 1'b0 || vsync_out !== 1'b0) begin n_bad++; $display("FAIL reset_sync got %b%b want 00", hsync_out, vsync_out); end
        n_vec++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL reset_underflow got %b want 0", underflow); end
        n_vec++; if (data_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", data_ready); end
        #1;
    endtask

    task automatic test_pattern();
        logic [5:0] want [8];
        want = '{6'h00, 6'h15, 6'h2A, 6'h3F, 6'h00, 6'h15, 6'h2A, 6'h3F};
        step(0, 0, 1, 0, 1, 16'h0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 16'h1B1B, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 10'(i), 0, 16'h0, 0, 0, 0, 0);
            n_vec++; if (rgb !== want[i]) begin n_bad++; $display("FAIL pattern_rgb px=%0d got %h want %h", i, rgb, want[i]); end
        end
        n_vec++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL pattern_underflow got %b want 0", underflow); end
    endtask

    task automatic test_full();
        logic want [7];
        want = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        step(0, 0, 1, 0, 1, 16'h0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            if (i < 5)       step(0, 0, 1, 0, 0, 16'hE400 + 16'(i), 1, 0, 0, 0);
            else if (i == 5) step(0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0);
            else             step(0, 0, 1, 0, 0, 16'h0, 0, 0, 0, 0);
            n_vec++; if (obs_ready !== want[i]) begin n_bad++; $display("FAIL full_ready cyc=%0d got %b want %b", i, obs_ready, want[i]); end
        end
        n_vec++; if (q_m.size() != 3) begin n_bad++; $display("FAIL full_model_occ got %0d want 3", q_m.size()); end
    endtask

    task automatic test_underflow();
        step(0, 0, 1, 0, 1, 16'h0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 10'(i), 0, 16'h0, 0, 0, 0, 0);
            n_vec++; if (rgb !== 6'h00 || underflow !== 1'b1) begin n_bad++; $display("FAIL underflow_line px=%0d got rgb=%h und=%b want rgb=00 und=1", i, rgb, underflow); end
        end
        step(0, 0, 1, 0, 0, 16'h0, 0, 0, 0, 0);
        n_vec++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL underflow_sticky got %b want 1", underflow); end
        step(0, 0, 1, 0, 1, 16'h0, 0, 0, 0, 0);
        n_vec++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL underflow_clear got %b want 0", underflow); end
        step(0, 0, 0, 0, 1, 16'h0, 0, 0, 0, 0);
        n_vec++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL underflow_vsync_wins got %b want 0", underflow); end
    endtask

    task automatic test_flush();
        step(0, 0, 1, 0, 1, 16'h0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 16'hFFFF, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1, 16'hFFFF, 1, 0, 0, 0);
        n_vec++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got %b want 0", obs_ready); end
        step(0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0);
        n_vec++; if (rgb !== 6'h00 || underflow !== 1'b1) begin n_bad++; $display("FAIL flush_empty got rgb=%h und=%b want rgb=00 und=1", rgb, underflow); end
    endtask

    task automatic test_palette();
        logic [5:0] want [8];
        want = '{6'h15, 6'h15, 6'h15, 6'h15, 6'h30, 6'h30, 6'h30, 6'h30};
        step(0, 0, 1, 0, 1, 16'h0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 16'h5555, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 10'(i), 0, 16'h0, 0, (i == 3), 2'd1, 6'h30);
            n_vec++; if (rgb !== want[i]) begin n_bad++; $display("FAIL palette_rgb px=%0d got %h want %h", i, rgb, want[i]); end
        end
    endtask

    task automatic test_random();
        int alen, blen;
        for (int line = 0; line < 60; line++) begin
            alen = 8 * $urandom_range(1, 3) + $urandom_range(0, 3);
            blen = $urandom_range(1, 6);
            for (int c = 0; c < alen + blen; c++) begin
                logic b;
                b = (c >= alen);
                step($urandom_range(0, 1), $urandom_range(0, 1), b, b ? 10'd0 : 10'(c),
                     ($urandom_range(0, 11) == 0), 16'($urandom), $urandom_range(0, 1),
                     ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), 6'($urandom));
                n_vec++;
                if (rgb !== exp_rgb || hsync_out !== exp_hs || vsync_out !== exp_vs ||
                    underflow !== und_m || obs_ready !== exp_ready) begin
                    n_bad++;
                    $display("FAIL random line=%0d c=%0d got rgb=%h hs=%b vs=%b und=%b rdy=%b want rgb=%h hs=%b vs=%b und=%b rdy=%b",
                             line, c, rgb, hsync_out, vsync_out, underflow, obs_ready,
                             exp_rgb, exp_hs, exp_vs, und_m, exp_ready);
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        step(0, 0, 1, 0, 1, 16'h0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 16'hFFFF, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 16'hFFFF, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 10'(i), 0, 16'h0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        n_vec++; if (rgb !== 6'h00 || hsync_out !== 1'b0 || vsync_out !== 1'b0 || underflow !== 1'b0 || data_ready !== 1'b1)
        begin n_bad++; $display("FAIL midline_reset got rgb=%h hs=%b vs=%b und=%b rdy=%b want 00 0 0 0 1", rgb, hsync_out, vsync_out, underflow, data_ready); end
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0);
        n_vec++; if (rgb !== 6'h00 || underflow !== 1'b1) begin n_bad++; $display("FAIL midline_no_survivor got rgb=%h und=%b want rgb=00 und=1", rgb, underflow); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pattern();
        test_full();
        test_underflow();
        test_flush();
        test_palette();
        test_random();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout vectors=%0d want completion", n_vec);
        $fatal(1, "timeout");
    end
endmodule
